// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding and
// status flag bit positions within the {V,C,N,Z} status word.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int STAT_V = 3;
  localparam int STAT_C = 2;
  localparam int STAT_N = 1;
  localparam int STAT_Z = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU. The master issues operations
// and consumes results; the slave is the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       status;

  modport master (
    output in_valid, A, B, c_in, sel, out_ready,
    input  in_ready, out_valid, out, status
  );

  modport slave (
    input  in_valid, A, B, c_in, sel, out_ready,
    output in_ready, out_valid, out, status
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier. The first step is taken on the
// start edge itself, so the full product is ready WIDTH edges after start.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] step_mc;
  logic [WIDTH:0]   step_sum;

  // {prod_hi, prod_lo} is the partial product; prod_lo starts as the multiplier
  // and its LSB decides whether the multiplicand is added before each shift.
  always_comb begin
    step_hi  = start ? '0 : prod_hi;
    step_lo  = start ? b  : prod_lo;
    step_mc  = start ? a  : mcand_q;
    step_sum = {1'b0, step_hi} + (step_lo[0] ? {1'b0, step_mc} : '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would chain updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        prod_hi <= step_sum[WIDTH:1];
        prod_lo <= {step_sum[0], step_lo[WIDTH-1:1]};
        if (start) begin
          mcand_q <= a;
          cnt_q   <= CW'(1);
          busy    <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops complete in one
// cycle, MUL runs on the iterative multiplier, results hold until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q;
  logic [3:0]       status_q;
  logic [WIDTH-1:0] res;
  logic [3:0]       status_d;
  logic             flag_c, flag_v;
  logic             load_res, mul_start, is_mul;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] prod_hi, prod_lo;

  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_sum;
  logic [SW-1:0]    shamt;
  logic             shift_big;

  assign is_mul = MUL_EN && (bus.sel == OP_MUL);

  // One adder serves ADD and SUB; SUB feeds ~B with a forced carry-in.
  assign is_sub    = (bus.sel == OP_SUB);
  assign add_b     = is_sub ? ~bus.B : bus.B;
  assign add_sum   = {1'b0, bus.A} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub | bus.c_in};
  assign shamt     = bus.B[SW-1:0];
  assign shift_big = |bus.B[WIDTH-1:SW];

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.A),
        .b       (bus.B),
        .busy    (mul_busy),
        .done    (mul_done),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign prod_hi  = '0;
      assign prod_lo  = '0;
    end
  endgenerate

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    state_d   = state_q;
    load_res  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            load_res = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done && !mul_busy) begin
          load_res = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // In BUSY the only result source is the multiplier; otherwise the live
  // request operands are decoded, which is the accept edge in IDLE.
  always_comb begin
    res    = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    if (state_q == ST_BUSY) begin
      res    = prod_lo;
      flag_c = |prod_hi;
    end else begin
      case (bus.sel)
        OP_ADD, OP_SUB: begin
          res    = add_sum[WIDTH-1:0];
          flag_c = add_sum[WIDTH];
          flag_v = (bus.A[WIDTH-1] == add_b[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
        end
        OP_XOR:  res = bus.A ^ bus.B;
        OP_AND:  res = bus.A & bus.B;
        OP_OR:   res = bus.A | bus.B;
        OP_NOR:  res = ~(bus.A | bus.B);
        OP_SRL:  res = shift_big ? '0 : (bus.A >> shamt);
        OP_SLL:  res = shift_big ? '0 : (bus.A << shamt);
        default: res = '0;
      endcase
    end
    status_d         = '0;
    status_d[STAT_V] = flag_v;
    status_d[STAT_C] = flag_c;
    status_d[STAT_N] = res[WIDTH-1];
    status_d[STAT_Z] = (res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_res) begin
        out_q    <= res;
        status_q <= status_d;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = out_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): a scoreboard queue of expected
// results and latencies is filled on each accept and drained on each result.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic [3:0]       status;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  int   lat_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference: wide arithmetic rather than bit-serial hardware.
  function automatic res_t model(input logic [3:0] sel, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    res_t        r;
    logic [32:0] s;
    logic [63:0] p;
    logic        v, c;
    r.out = '0;
    v     = 1'b0;
    c     = 1'b0;
    case (sel)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        r.out = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.out = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'd2: r.out = a ^ b;
      4'd3: r.out = a & b;
      4'd4: r.out = a | b;
      4'd5: r.out = ~(a | b);
      4'd6: r.out = (b >= 32) ? 32'd0 : (a >> b[4:0]);
      4'd7: r.out = (b >= 32) ? 32'd0 : (a << b[4:0]);
      4'd8: begin
        p = {32'd0, a} * {32'd0, b};
        r.out = p[31:0];
        c = (p[63:32] != 32'd0);
      end
      default: r.out = '0;
    endcase
    r.status = {v, c, r.out[31], (r.out == 32'd0)};
    return r;
  endfunction

  function automatic res_t mk(input logic [31:0] o, input logic [3:0] st);
    res_t r;
    r.out    = o;
    r.status = st;
    return r;
  endfunction

  // Issue one request; called #1 after an edge, returns #1 after the accept edge.
  task automatic send(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input res_t e);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b, required 1", bus.in_ready);
    end
    bus.sel = sel; bus.A = a; bus.B = b; bus.c_in = cin; bus.in_valid = 1'b1;
    exp_q.push_back(e);
    lat_q.push_back((sel == OP_MUL) ? WIDTH + 1 : 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for a result (lat0 = cycles since accept at entry), compare, optionally
  // stall for 'hold' cycles, then complete the handshake.
  task automatic receive(input string name, input int hold, input int lat0);
    res_t e;
    int   exp_lat, lat;
    lat = lat0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got a result with no expectation queued", name);
      return;
    end
    e       = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, bus.out_valid, lat);
      return;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.out !== e.out) begin
      errors++;
      $display("FAIL %s out: got %h, required %h", name, bus.out, e.out);
    end
    checks++;
    if (bus.status !== e.status) begin
      errors++;
      $display("FAIL %s status: got %b, required %b", name, bus.status, e.status);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out !== e.out || bus.status !== e.status) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b ready=%b out=%h status=%b, required 1 0 %h %b",
                 name, i, bus.out_valid, bus.in_ready, bus.out, bus.status, e.out, e.status);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: in_ready=%b out_valid=%b, required 1 0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.sel = OP_ADD; bus.A = 32'd2; bus.B = 32'd3; bus.c_in = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== 32'd0 || bus.status !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b out=%h status=%b, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out, bus.status);
    end
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_accept: out_valid high %0d cycles, required 0", seen);
    end
  endtask

  task automatic test_add_sub();
    logic [31:0] a, b;
    logic        cin;
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, mk(32'd0, 4'b0101));
    receive("add_wrap", 0, 1);
    send(OP_SUB, 32'h8000_0000, 32'd1, 1'b0, mk(32'h7FFF_FFFF, 4'b1100));
    receive("sub_ovf", 0, 1);
    send(OP_ADD, 32'h7FFF_FFFF, 32'd0, 1'b1, mk(32'h8000_0000, 4'b1010));
    receive("add_cin_ovf", 0, 1);
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      send(4'(i % 2), a, b, cin, model(4'(i % 2), a, b, cin));
      receive("add_sub_rand", 0, 1);
    end
  endtask

  task automatic test_logic_shift();
    logic [31:0] a, b;
    for (int op = 2; op <= 7; op++) begin
      for (int k = 0; k < 3; k++) begin
        a = $urandom;
        b = (op >= 6) ? 32'($urandom_range(0, 40)) : 32'($urandom);
        send(4'(op), a, b, 1'b1, model(4'(op), a, b, 1'b1));
        receive("logic_shift", 0, 1);
      end
    end
  endtask

  task automatic test_mul();
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, mk(32'd0, 4'b0101));
    receive("mul_hi_only", 0, 1);
    send(OP_MUL, 32'd7, 32'd6, 1'b0, mk(32'd42, 4'b0000));
    receive("mul_7x6", 0, 1);
    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, model(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
    receive("mul_max", 0, 1);
  endtask

  task automatic test_backpressure();
    send(OP_ADD, 32'd2, 32'd3, 1'b0, mk(32'd5, 4'b0000));
    receive("add_hold5", 5, 1);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    bus.sel = OP_MUL; bus.A = 32'd7; bus.B = 32'd6; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 0;
    repeat (9) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out !== 32'd0 || bus.status !== 4'd0) begin
      errors++;
      $display("FAIL mid_mul_reset_state: ready=%b out=%h status=%b, required 1 0 0",
               bus.in_ready, bus.out, bus.status);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_mul_discard: out_valid high %0d cycles, required 0", seen);
    end
    send(OP_ADD, 32'd2, 32'd3, 1'b0, mk(32'd5, 4'b0000));
    receive("add_after_reset", 0, 1);
  endtask

  task automatic test_shift_illegal();
    send(OP_SLL, 32'd1, 32'd31, 1'b0, mk(32'h8000_0000, 4'b0010));
    receive("sll_31", 0, 1);
    send(OP_SLL, 32'd1, 32'd32, 1'b0, mk(32'd0, 4'b0001));
    receive("sll_32", 0, 1);
    send(OP_SRL, 32'hFFFF_FFFF, 32'h0000_0100, 1'b0, mk(32'd0, 4'b0001));
    receive("srl_big", 0, 1);
    for (int op = 9; op <= 15; op++) begin
      send(4'(op), 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, mk(32'd0, 4'b0001));
      receive("illegal", 0, 1);
    end
  endtask

  task automatic test_ignore_busy();
    int bad;
    send(OP_MUL, 32'd7, 32'd6, 1'b0, mk(32'd42, 4'b0000));
    bus.sel = OP_ADD; bus.A = 32'd1; bus.B = 32'd1; bus.in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      if (bus.in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_in_ready: high %0d cycles in BUSY, required 0", bad);
    end
    receive("mul_ignore_in", 2, 11);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        cin;
    for (int i = 0; i < 8; i++) begin
      op  = 4'($urandom_range(0, 8));
      a   = $urandom; b = (op == OP_SRL || op == OP_SLL) ? 32'($urandom_range(0, 35)) : 32'($urandom);
      cin = 1'($urandom_range(0, 1));
      send(op, a, b, cin, model(op, a, b, cin));
      receive("back_to_back", $urandom_range(0, 2), 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_shift_illegal();
    test_ignore_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
Parameters:
REQ-001 WIDTH, 32, operand and result width in bits; SHALL be >= 4 and a power of two.
REQ-002 MUL_EN, 1, SHALL enable the iterative MUL op when 1; when 0, MUL SHALL be treated as an illegal op.
Ports (one clock; reset is synchronous and active-high):
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B; also the shift amount.
REQ-009 c_in  input  1  carry-in, used by ADD only.
REQ-010 sel  input  4  opcode.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  WIDTH  registered result.
REQ-014 status  output  4  registered flags {V,C,N,Z}.

Function
REQ-015 Opcodes SHALL be: 0 ADD (A+B+c_in), 1 SUB (A+~B+1), 2 XOR, 3 AND, 4 OR, 5 NOR, 6 SRL (A>>B), 7 SLL (A<<B), 8 MUL (low WIDTH bits of A*B, unsigned); 9-15 are illegal.
REQ-016 FSM states SHALL be IDLE, BUSY and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 on a rising edge, and operands and sel SHALL be captured at that edge.
REQ-018 A non-MUL accept SHALL go IDLE->DONE, with out_valid=1 on the cycle after the accept (latency 1).
REQ-019 A MUL accept SHALL go IDLE->BUSY; the shift-add iteration SHALL take exactly WIDTH cycles; the state SHALL then go BUSY->DONE, giving out_valid exactly WIDTH+1 cycles after the accept.
REQ-020 In DONE, out and status SHALL hold stable until out_valid and out_ready are both 1; the state SHALL then go DONE->IDLE on that edge.
REQ-021 in_valid SHALL be ignored in BUSY and DONE; there is no queuing.
REQ-022 Shifts SHALL produce 0 when B >= WIDTH, and otherwise shift by B[log2(WIDTH)-1:0], zero-filling.
REQ-023 Z SHALL be 1 when out == 0, and N SHALL equal out[WIDTH-1], for all ops.
REQ-024 C SHALL be the carry out of the WIDTH-bit adder for ADD and SUB (SUB: C=1 means no borrow); for MUL, C SHALL be 1 if the upper WIDTH bits of the full product are nonzero; for all other ops, C SHALL be 0.
REQ-025 V SHALL be the two's-complement overflow for ADD (operands of the same sign, result of the other sign) and for SUB (operands of differing sign, result sign differs from A); for all other ops, V SHALL be 0.
REQ-026 An illegal op SHALL complete with latency 1, out=0 and status=4'b0001.
REQ-027 out and status SHALL change only on the DONE entry edge.

Reset
REQ-028 rst=1 SHALL force the state to IDLE, out_valid=0, out=0, status=0 and all multiplier state to 0 on the next edge, from any state, including mid-MUL; a partial result SHALL be discarded and never presented.
REQ-029 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-030 A request presented while rst=1 SHALL NOT be accepted.

Structure
REQ-031 The opcode localparams, the FSM state encoding and the status bit indices SHALL live in a shared package, alu_pkg.
REQ-032 The iterative multiplier SHALL be a sub-module, alu_mul_iter (start, busy/done, WIDTH-cycle shift-add, product high and low), instantiated only when MUL_EN=1.
REQ-033 The single-cycle datapath SHALL be combinational logic feeding the result and status registers, using one shared adder for ADD and SUB.

Verification (WIDTH=32)
REQ-034 ADD A=0xFFFFFFFF, B=1, c_in=0 -> out=0, status=4'b0101, out_valid exactly 1 cycle after the accept.
REQ-035 SUB A=0x80000000, B=1 -> out=0x7FFFFFFF, status=4'b1100.
REQ-036 MUL A=0x00010000, B=0x00010000 -> out=0, status=4'b0101, out_valid exactly 33 cycles after the accept; then MUL A=7, B=6 -> out=42, status=0.
REQ-037 ADD 2+3 with out_ready=0 for 5 cycles -> out=5 held, out_valid=1, in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
REQ-038 rst pulsed at cycle 10 of a MUL -> out_valid never rises for that MUL; in_ready=1 after reset; ADD 2+3 then gives out=5.
REQ-039 SLL A=1, B=31 -> out=0x80000000, status=4'b0010; SLL A=1, B=32 -> out=0, status=4'b0001; sel=12 -> out=0, status=4'b0001.
